// File: rtl/pipe_hazard_sched.sv
// Issue-stage scheduler: per-register writeback scoreboard for RAW/WAW stalls,
// plus a branch freeze FSM that raises a one-cycle flush on a taken branch.
module pipe_hazard_sched #(
    parameter int NREG   = 32,
    parameter int WB_LAT = 8,
    parameter int BRA_OP = 21
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [5:0]      id_op,
    input  logic [4:0]      id_rd,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic            ex_br_resolve,
    input  logic            ex_br_taken,
    output logic            issue,
    output logic            stall,
    output logic            flush,
    output logic            br_pending,
    output logic [NREG-1:0] busy_mask
);

    // state   | meaning
    // IDLE    | no branch outstanding, issue governed by the scoreboard only
    // BR_WAIT | branch issued and unresolved, all issue blocked
    typedef enum logic {
        IDLE    = 1'b0,
        BR_WAIT = 1'b1
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(WB_LAT);
    localparam logic [5:0] BRA_CODE = 6'(BRA_OP);

    state_t     state;
    state_t     state_nxt;
    logic       flush_q;
    logic       flush_nxt;
    logic       writer;
    logic       hazard;
    logic       do_load;
    logic [3:0] cnt [1:NREG-1];

    always_comb begin
        case (id_op)
            6'd1, 6'd2, 6'd23, 6'd24: writer = 1'b1;
            default:                  writer = (id_op >= 6'd4) && (id_op <= 6'd20);
        endcase
    end

    // r0 has no counter, so its busy bit is tied low and never causes a hazard
    assign busy_mask[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        assign busy_mask[r] = (cnt[r] != 4'd0);

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt[r] <= 4'd0;
            end else if (do_load && (id_rd == 5'(r))) begin
                cnt[r] <= LAT_LOAD;
            end else if (cnt[r] != 4'd0) begin
                cnt[r] <= cnt[r] - 4'd1;
            end
        end
    end

    assign hazard = (id_use_rs1 & busy_mask[id_rs1])
                  | (id_use_rs2 & busy_mask[id_rs2])
                  | (writer     & busy_mask[id_rd])
                  | br_pending;

    assign issue   = id_valid & ~hazard & ~reset;
    assign stall   = id_valid &  hazard & ~reset;
    assign do_load = issue & writer & (id_rd != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            flush_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            flush_q <= flush_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue && (id_op == BRA_CODE)) state_nxt = BR_WAIT;
            BR_WAIT: if (ex_br_resolve)                state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        br_pending = (state == BR_WAIT);
        flush_nxt  = (state == BR_WAIT) & ex_br_resolve & ex_br_taken;
    end

    assign flush = flush_q & ~reset;

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Scoreboard bench for pipe_hazard_sched: a timestamp-based reference model
// predicts each cycle's outputs; directed scenarios plus a random run.
module tb_pipe_hazard_sched;

    localparam int NREG   = 32;
    localparam int WB_LAT = 8;
    localparam int BRA_OP = 21;

    logic            clk = 1'b0;
    logic            reset;
    logic            id_valid;
    logic [5:0]      id_op;
    logic [4:0]      id_rd, id_rs1, id_rs2;
    logic            id_use_rs1, id_use_rs2;
    logic            ex_br_resolve, ex_br_taken;
    logic            issue, stall, flush, br_pending;
    logic [NREG-1:0] busy_mask;

    pipe_hazard_sched #(.NREG(NREG), .WB_LAT(WB_LAT), .BRA_OP(BRA_OP)) dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_op         (id_op),
        .id_rd         (id_rd),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .ex_br_resolve (ex_br_resolve),
        .ex_br_taken   (ex_br_taken),
        .issue         (issue),
        .stall         (stall),
        .flush         (flush),
        .br_pending    (br_pending),
        .busy_mask     (busy_mask)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [5:0] op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
    } instr_t;

    typedef struct packed {
        logic            issue;
        logic            stall;
        logic            flush;
        logic            brp;
        logic [NREG-1:0] mask;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // reference model state: cycle at which each register becomes readable
    int   ready_at [NREG];
    int   cyc = 0;
    logic m_brp = 1'b0;
    logic m_flush_q = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit is_writer(input logic [5:0] op);
        return op inside {6'd1, 6'd2, [6'd4:6'd20], 6'd23, 6'd24};
    endfunction

    function automatic bit m_busy(input logic [4:0] r);
        return (r != 5'd0) && (cyc < ready_at[r]);
    endfunction

    function automatic instr_t ins(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic u1, input logic u2);
        instr_t i;
        i.v = 1'b1; i.op = op; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.u1 = u1; i.u2 = u2;
        return i;
    endfunction

    function automatic instr_t bubble();
        instr_t i;
        i = '0;
        return i;
    endfunction

    task automatic step(input instr_t i, input logic res, input logic tkn, input logic rst,
                        output logic got_issue, output logic got_flush);
        exp_t e;
        exp_t g;
        logic haz;
        logic m_issue;
        @(posedge clk);
        #1;
        reset = rst; id_valid = i.v; id_op = i.op; id_rd = i.rd; id_rs1 = i.rs1; id_rs2 = i.rs2;
        id_use_rs1 = i.u1; id_use_rs2 = i.u2; ex_br_resolve = res; ex_br_taken = tkn;

        haz = (i.u1 && m_busy(i.rs1)) || (i.u2 && m_busy(i.rs2))
            || (is_writer(i.op) && m_busy(i.rd)) || m_brp;
        m_issue = i.v && !haz && !rst;
        e.issue = m_issue;
        e.stall = i.v && haz && !rst;
        e.flush = m_flush_q && !rst;
        e.brp   = m_brp;
        for (int r = 0; r < NREG; r++) e.mask[r] = m_busy(5'(r));
        sb.push_back(e);

        @(negedge clk);
        g = sb.pop_front();
        check("issue", 32'(issue), 32'(g.issue));
        check("stall", 32'(stall), 32'(g.stall));
        check("flush", 32'(flush), 32'(g.flush));
        check("br_pending", 32'(br_pending), 32'(g.brp));
        check("busy_mask", busy_mask, g.mask);
        got_issue = issue;
        got_flush = flush;

        if (rst) begin
            for (int r = 0; r < NREG; r++) ready_at[r] = 0;
            m_brp = 1'b0;
            m_flush_q = 1'b0;
        end else begin
            if (m_issue && is_writer(i.op) && i.rd != 5'd0) ready_at[i.rd] = cyc + WB_LAT + 1;
            m_flush_q = m_brp && res && tkn;
            if (m_brp && res) m_brp = 1'b0;
            else if (m_issue && i.op == 6'(BRA_OP)) m_brp = 1'b1;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        logic gi, gf;
        for (int k = 0; k < n; k++) step(bubble(), 1'b0, 1'b0, 1'b0, gi, gf);
    endtask

    task automatic go(input instr_t i);
        logic gi, gf;
        step(i, 1'b0, 1'b0, 1'b0, gi, gf);
    endtask

    // present i until it issues; returns the number of stalled cycles
    task automatic hold(input instr_t i, output int stalls);
        logic gi, gf;
        stalls = 0;
        for (int k = 0; k < 40; k++) begin
            step(i, 1'b0, 1'b0, 1'b0, gi, gf);
            if (gi) return;
            stalls++;
        end
        check("hold_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int   st;
        logic gi, gf;
        logic [5:0] ops [8] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd5, 6'd21, 6'd23, 6'd30};
        instr_t ri;

        for (int r = 0; r < NREG; r++) ready_at[r] = 0;
        reset = 1'b1; id_valid = 1'b0; id_op = '0; id_rd = '0; id_rs1 = '0; id_rs2 = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_br_resolve = 1'b0; ex_br_taken = 1'b0;
        repeat (2) @(posedge clk);

        step(ins(6'd1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0), 1'b0, 1'b0, 1'b1, gi, gf);
        idle(2);

        // RAW on r5
        go(ins(6'd1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0));
        hold(ins(6'd0, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0), st);
        check("raw_stalls", 32'(st), 32'(WB_LAT));

        // WAW on r7
        go(ins(6'd2, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0));
        hold(ins(6'd4, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0), st);
        check("waw_stalls", 32'(st), 32'(WB_LAT));
        idle(10);

        // r0 is never tracked
        go(ins(6'd1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0));
        hold(ins(6'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1), st);
        check("r0_stalls", 32'(st), 32'd0);
        check("r0_mask", busy_mask, 32'd0);

        // non-writers leave the scoreboard untouched
        go(ins(6'd3, 5'd9, 5'd1, 5'd2, 1'b1, 1'b1));
        go(ins(6'd0, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0));
        hold(ins(6'd5, 5'd11, 5'd9, 5'd10, 1'b1, 1'b1), st);
        check("nonwriter_stalls", 32'(st), 32'd0);
        idle(10);

        // taken branch
        go(ins(6'(BRA_OP), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0));
        check("br_enter", 32'(br_pending), 32'd0);
        for (int k = 0; k < 4; k++) step(ins(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0, gi, gf);
        check("br_blocked", 32'(gi), 32'd0);
        step(ins(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0), 1'b1, 1'b1, 1'b0, gi, gf);
        check("br_resolve_cycle_issue", 32'(gi), 32'd0);
        step(ins(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0, gi, gf);
        check("br_taken_flush", 32'(gf), 32'd1);
        check("br_resume_issue", 32'(gi), 32'd1);

        // not-taken branch, then a spurious resolve in IDLE
        go(ins(6'(BRA_OP), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0));
        idle(2);
        step(bubble(), 1'b1, 1'b0, 1'b0, gi, gf);
        step(bubble(), 1'b1, 1'b1, 1'b0, gi, gf);
        check("nt_flush", 32'(gf), 32'd0);
        step(bubble(), 1'b0, 1'b0, 1'b0, gi, gf);
        check("spurious_flush", 32'(gf), 32'd0);
        check("spurious_brp", 32'(br_pending), 32'd0);

        // branch with a RAW hazard waits for the hazard, then enters BR_WAIT
        go(ins(6'd23, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0));
        hold(ins(6'(BRA_OP), 5'd0, 5'd12, 5'd0, 1'b1, 1'b0), st);
        check("br_raw_stalls", 32'(st), 32'(WB_LAT));
        step(bubble(), 1'b1, 1'b1, 1'b0, gi, gf);
        idle(2);

        // reset mid-operation
        go(ins(6'd1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0));
        go(ins(6'd2, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0));
        go(ins(6'd24, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0));
        go(ins(6'(BRA_OP), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0));
        step(ins(6'd0, 5'd0, 5'd3, 5'd4, 1'b1, 1'b1), 1'b1, 1'b1, 1'b1, gi, gf);
        check("rst_cycle_issue", 32'(gi), 32'd0);
        step(ins(6'd0, 5'd0, 5'd3, 5'd6, 1'b1, 1'b1), 1'b0, 1'b0, 1'b0, gi, gf);
        check("post_rst_issue", 32'(gi), 32'd1);
        check("post_rst_mask", busy_mask, 32'd0);
        check("post_rst_flush", 32'(gf), 32'd0);

        // random traffic over a small register window
        for (int k = 0; k < 600; k++) begin
            ri.v   = ($urandom_range(0, 3) != 0);
            ri.op  = ops[$urandom_range(0, 7)];
            ri.rd  = 5'($urandom_range(0, 7));
            ri.rs1 = 5'($urandom_range(0, 7));
            ri.rs2 = 5'($urandom_range(0, 7));
            ri.u1  = 1'($urandom_range(0, 1));
            ri.u2  = 1'($urandom_range(0, 1));
            step(ri, ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) == 0), gi, gf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
